// File: rtl/fft_64p_out_collector.sv
// Collects one 64-sample FFT output frame into a register buffer (bit-reversed write order by default)
// and drains it in natural bin order over a valid/ready handshake.
module fft_64p_out_collector #(
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Out_Stream,
  input  logic        Data_Out,
  input  logic        Rd_Ready,
  output logic        Rd_Valid,
  output logic [31:0] Rd_Data,
  output logic        Rd_Last,
  output logic        Frame_Done,
  output logic        Overrun,
  output logic        Busy
);

  // state   | meaning
  // IDLE    | waiting for the first sample of a frame
  // CAPTURE | storing samples 1..63, gaps allowed
  // DRAIN   | presenting bins 0..63; new samples are dropped
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  wr_cnt_q, wr_cnt_d;
  logic [5:0]  rd_cnt_q, rd_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        overrun_q, overrun_d;
  logic        wr_en;
  logic [5:0]  wa;
  logic [31:0] mem [64];

  always_comb begin
    wa = BIT_REVERSE ? {wr_cnt_q[0], wr_cnt_q[1], wr_cnt_q[2],
                        wr_cnt_q[3], wr_cnt_q[4], wr_cnt_q[5]} : wr_cnt_q;
  end

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    wr_en        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Data_Out) begin
          wr_en    = 1'b1;
          wr_cnt_d = 6'd1;
          state_d  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (Data_Out) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + 6'd1;
          if (wr_cnt_q == 6'd63) begin
            state_d      = S_DRAIN;
            frame_done_d = 1'b1;
            rd_cnt_d     = 6'd0;
          end
        end
      end
      S_DRAIN: begin
        if (Data_Out) overrun_d = 1'b1;
        if (Rd_Ready) begin
          rd_cnt_d = rd_cnt_q + 6'd1;
          if (rd_cnt_q == 6'd63) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wr_cnt_q     <= 6'd0;
      rd_cnt_q     <= 6'd0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Buffer contents survive reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wa] <= Out_Stream;
  end

  assign Rd_Valid   = (state_q == S_DRAIN);
  assign Rd_Data    = Rd_Valid ? mem[rd_cnt_q] : 32'd0;
  assign Rd_Last    = Rd_Valid && (rd_cnt_q == 6'd63);
  assign Frame_Done = frame_done_q;
  assign Overrun    = overrun_q;
  assign Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fft_64p_out_collector.sv
// Bench for fft_64p_out_collector: a bit-reversing and a natural-order instance share stimulus and are
// checked every cycle against a queue/array frame model, plus hand-computed timing and data points.
module tb_fft_64p_out_collector;

  logic        clk;
  logic        rst;
  logic [31:0] Out_Stream;
  logic        Data_Out;
  logic        Rd_Ready;

  logic [1:0]  rd_valid, rd_last, frame_done, overrun, busy;
  logic [31:0] rd_data [2];

  fft_64p_out_collector #(.BIT_REVERSE(1'b1)) dut (
    .clk(clk), .rst(rst), .Out_Stream(Out_Stream), .Data_Out(Data_Out), .Rd_Ready(Rd_Ready),
    .Rd_Valid(rd_valid[0]), .Rd_Data(rd_data[0]), .Rd_Last(rd_last[0]),
    .Frame_Done(frame_done[0]), .Overrun(overrun[0]), .Busy(busy[0]));

  fft_64p_out_collector #(.BIT_REVERSE(1'b0)) dut_nat (
    .clk(clk), .rst(rst), .Out_Stream(Out_Stream), .Data_Out(Data_Out), .Rd_Ready(Rd_Ready),
    .Rd_Valid(rd_valid[1]), .Rd_Data(rd_data[1]), .Rd_Last(rd_last[1]),
    .Frame_Done(frame_done[1]), .Overrun(overrun[1]), .Busy(busy[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int bitrev6(input int i);
    logic [5:0] v;
    logic [5:0] r;
    v = i[5:0];
    for (int b = 0; b < 6; b++) r[b] = v[5 - b];
    return int'(r);
  endfunction

  // Model: collect samples in arrival order; on the 64th, scatter them into bin order and drain.
  logic [31:0] m_cap  [2][64];
  logic [31:0] m_bins [2][64];
  int          m_cap_n [2];
  int          m_rd    [2];
  bit          m_drain [2];
  bit          m_fd    [2];
  bit          m_ovr   [2];

  function automatic int bin_of(input int j, input int i);
    return (j == 0) ? bitrev6(i) : i;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 2; j++) begin
        m_cap_n[j] <= 0;
        m_rd[j]    <= 0;
        m_drain[j] <= 1'b0;
        m_fd[j]    <= 1'b0;
        m_ovr[j]   <= 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        m_fd[j] <= 1'b0;
        if (m_drain[j]) begin
          if (Data_Out) m_ovr[j] <= 1'b1;
          if (Rd_Ready) begin
            if (m_rd[j] == 63) begin
              m_drain[j] <= 1'b0;
              m_rd[j]    <= 0;
            end else begin
              m_rd[j] <= m_rd[j] + 1;
            end
          end
        end else if (Data_Out) begin
          if (m_cap_n[j] == 63) begin
            for (int i = 0; i < 63; i++) m_bins[j][bin_of(j, i)] <= m_cap[j][i];
            m_bins[j][bin_of(j, 63)] <= Out_Stream;
            m_cap_n[j] <= 0;
            m_drain[j] <= 1'b1;
            m_rd[j]    <= 0;
            m_fd[j]    <= 1'b1;
          end else begin
            m_cap[j][m_cap_n[j]] <= Out_Stream;
            m_cap_n[j] <= m_cap_n[j] + 1;
          end
        end
      end
    end
  end

  // Compare process plus a transfer log of the bit-reversing instance.
  logic [31:0] obs [1024];
  int xfer_total = 0;
  int last_at = -1;
  int fd_cyc = -1;
  int last_cyc = -1;
  int idle_cyc = -1;
  bit prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        chk(j == 0 ? "br.valid" : "nat.valid", {31'd0, rd_valid[j]}, {31'd0, m_drain[j]});
        chk(j == 0 ? "br.data" : "nat.data", rd_data[j],
            m_drain[j] ? m_bins[j][m_rd[j]] : 32'd0);
        chk(j == 0 ? "br.last" : "nat.last", {31'd0, rd_last[j]},
            {31'd0, m_drain[j] && (m_rd[j] == 63)});
        chk(j == 0 ? "br.frame_done" : "nat.frame_done", {31'd0, frame_done[j]}, {31'd0, m_fd[j]});
        chk(j == 0 ? "br.overrun" : "nat.overrun", {31'd0, overrun[j]}, {31'd0, m_ovr[j]});
        chk(j == 0 ? "br.busy" : "nat.busy", {31'd0, busy[j]},
            {31'd0, m_drain[j] || (m_cap_n[j] > 0)});
      end
      if (rd_valid[0] && Rd_Ready) begin
        obs[xfer_total % 1024] <= rd_data[0];
        if (rd_last[0]) last_at <= xfer_total;
        xfer_total <= xfer_total + 1;
      end
      if (frame_done[0]) fd_cyc <= cyc;
      if (rd_last[0]) last_cyc <= cyc;
      if (prev_busy && !busy[0]) idle_cyc <= cyc;
      prev_busy <= busy[0];
    end else begin
      prev_busy <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sample(input int kind, input int i);
    logic [15:0] v;
    v = i[15:0];
    case (kind)
      0:       return {v, ~v};
      1:       return 32'h0029_0000;
      default: return 32'h1234_0000 + 32'(i * 3);
    endcase
  endfunction

  // Returns the cycle in which the first sample was presented.
  task automatic send_frame(input int kind, input bit gapped, output int n0);
    n0 = cyc;
    for (int i = 0; i < 64; i++) begin
      Out_Stream = sample(kind, i);
      Data_Out   = 1'b1;
      tick();
      if (gapped) begin
        Data_Out = 1'b0;
        tick();
      end
    end
    Data_Out = 1'b0;
  endtask

  task automatic drain(input bit backpressure);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      Rd_Ready = backpressure ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
      tick();
      if (!busy[0] && !busy[1]) done = 1'b1;
    end
    Rd_Ready = 1'b1;
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] ramp_ref [64];

  task automatic cmp_ramp(input string nm, input int base);
    int bad;
    bad = 0;
    for (int k = 0; k < 64; k++) if (obs[(base + k) % 1024] !== ramp_ref[k]) bad++;
    chk(nm, 32'(bad), 32'd0);
  endtask

  int n0;
  int base;

  initial begin
    rst = 1'b0; Data_Out = 1'b0; Rd_Ready = 1'b0; Out_Stream = 32'd0;
    tick(); tick(); tick();
    chk("reset.valid", {31'd0, rd_valid[0]}, 32'd0);
    chk("reset.data", rd_data[0], 32'd0);
    chk("reset.busy", {30'd0, busy}, 32'd0);
    chk("reset.overrun", {30'd0, overrun}, 32'd0);
    rst = 1'b1;
    Rd_Ready = 1'b1;
    tick(); tick();

    // Contiguous ramp.
    base = xfer_total;
    send_frame(0, 1'b0, n0);
    drain(1'b0);
    tick();
    chk("ramp.frame_done_cycle", 32'(fd_cyc - n0), 32'd64);
    chk("ramp.last_cycle", 32'(last_cyc - n0), 32'd127);
    chk("ramp.idle_cycle", 32'(idle_cyc - n0), 32'd128);
    chk("ramp.xfers", 32'(xfer_total - base), 32'd64);
    chk("ramp.last_index", 32'(last_at - base), 32'd63);
    chk("ramp.bin0", obs[base], 32'h0000_FFFF);
    chk("ramp.bin1", obs[base + 1], 32'h0020_FFDF);
    chk("ramp.bin63", obs[base + 63], 32'h003F_FFC0);
    for (int k = 0; k < 64; k++) ramp_ref[k] = obs[base + k];

    // Constant frame, checked on both instances by the model.
    base = xfer_total;
    send_frame(1, 1'b0, n0);
    drain(1'b0);
    tick();
    chk("const.xfers", 32'(xfer_total - base), 32'd64);
    chk("const.bin37", obs[base + 37], 32'h0029_0000);
    chk("const.valid_after", {30'd0, rd_valid}, 32'd0);

    // Gapped ramp.
    base = xfer_total;
    send_frame(0, 1'b1, n0);
    drain(1'b0);
    tick();
    chk("gap.frame_done_cycle", 32'(fd_cyc - n0), 32'd127);
    chk("gap.xfers", 32'(xfer_total - base), 32'd64);
    cmp_ramp("gap.contents", base);

    // Backpressure 1,0,0,1.
    base = xfer_total;
    send_frame(0, 1'b0, n0);
    drain(1'b1);
    tick();
    chk("bp.xfers", 32'(xfer_total - base), 32'd64);
    chk("bp.last_index", 32'(last_at - base), 32'd63);
    cmp_ramp("bp.contents", base);

    // Overrun: three samples arrive mid-drain.
    base = xfer_total;
    send_frame(0, 1'b0, n0);
    tick(); tick(); tick(); tick();
    Out_Stream = 32'hDEAD_BEEF;
    Data_Out = 1'b1;
    tick(); tick(); tick();
    Data_Out = 1'b0;
    chk("ovr.flag", {30'd0, overrun}, 32'd3);
    drain(1'b0);
    tick();
    chk("ovr.sticky_idle", {30'd0, overrun}, 32'd3);
    chk("ovr.xfers", 32'(xfer_total - base), 32'd64);
    cmp_ramp("ovr.contents", base);
    base = xfer_total;
    send_frame(2, 1'b0, n0);
    drain(1'b0);
    tick();
    chk("ovr.next_bin1", obs[base + 1], 32'h1234_0000 + 32'd96);
    chk("ovr.next_xfers", 32'(xfer_total - base), 32'd64);

    // Asynchronous reset partway through a capture.
    for (int i = 0; i < 30; i++) begin
      Out_Stream = 32'hCAFE_0000 + 32'(i);
      Data_Out = 1'b1;
      tick();
    end
    Data_Out = 1'b0;
    chk("arst.busy_before", {30'd0, busy}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.valid", {30'd0, rd_valid}, 32'd0);
    chk("arst.data", rd_data[0] | rd_data[1], 32'd0);
    chk("arst.last", {30'd0, rd_last}, 32'd0);
    chk("arst.frame_done", {30'd0, frame_done}, 32'd0);
    chk("arst.overrun", {30'd0, overrun}, 32'd0);
    chk("arst.busy", {30'd0, busy}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    base = xfer_total;
    send_frame(0, 1'b0, n0);
    drain(1'b0);
    tick();
    chk("arst.fd_cycle", 32'(fd_cyc - n0), 32'd64);
    chk("arst.xfers", 32'(xfer_total - base), 32'd64);
    cmp_ramp("arst.contents", base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_64p_out_collector.md
# fft_64p_out_collector

Receive-side companion to `fft_64p_16b_top`. It captures one 64-sample output frame from the FFT's `Out_Stream`/`Data_Out` interface into an internal 64×32 register buffer. Samples are written in bit-reversed order by default, so the buffer holds bins in natural order. The frame is then drained to a downstream consumer over a valid/ready handshake. It sits between the FFT core and any sink (host interface, magnitude unit, bench scoreboard) and gives the FFT core a sink that never applies backpressure during capture.

## Interface
- `BIT_REVERSE`, default 1: 1 = write address is the 6-bit bit-reverse of the arrival index; 0 = write address equals the arrival index.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `Out_Stream`  input  32  FFT output sample, {real[31:16], imag[15:0]}, two's complement.
- `Data_Out`  input  1  FFT output-valid strobe; when 1, `Out_Stream` carries a sample this cycle.
- `Rd_Ready`  input  1  downstream accepts `Rd_Data` this cycle.
- `Rd_Valid`  output  1  `Rd_Data` holds a valid bin.
- `Rd_Data`  output  32  bin data, {real, imag}; forced to 0 whenever `Rd_Valid`=0.
- `Rd_Last`  output  1  qualifies bin 63; equals `Rd_Valid` AND (read pointer == 63).
- `Frame_Done`  output  1  one-cycle pulse when the 64th sample has been captured.
- `Overrun`  output  1  sticky flag: a sample arrived while draining and was dropped.
- `Busy`  output  1  1 in CAPTURE or DRAIN.

## Operation
- Storage: 64 × 32-bit register array, `mem`. It is not cleared by reset. Reads are combinational from the read pointer.
- Counters: `wr_cnt` and `rd_cnt`, both 6-bit unsigned.
- Write address: `wa = BIT_REVERSE ? {wr_cnt[0],wr_cnt[1],…,wr_cnt[5]} : wr_cnt`.
- FSM has three states: IDLE, CAPTURE, DRAIN.
- IDLE
  - If `Data_Out`=1: write `mem[wa(0)] <= Out_Stream`, set `wr_cnt <= 1`, go to CAPTURE.
  - Otherwise hold.
- CAPTURE
  - Each cycle with `Data_Out`=1: write `mem[wa(wr_cnt)]`, increment `wr_cnt`.
  - Cycles with `Data_Out`=0 are gaps: no write, counter holds, no timeout.
  - When the write at `wr_cnt`=63 occurs: `wr_cnt` wraps to 0, state goes to DRAIN, `Frame_Done` pulses, `rd_cnt <= 0`.
- DRAIN
  - `Rd_Valid`=1 and `Rd_Data = mem[rd_cnt]`.
  - A transfer happens when `Rd_Valid`=1 and `Rd_Ready`=1; `rd_cnt` then increments.
  - A transfer at `rd_cnt`=63 returns the FSM to IDLE and wraps `rd_cnt` to 0.
  - With `Rd_Ready`=0: `Rd_Data`, `Rd_Last` and `rd_cnt` hold.
- Overrun handling
  - `Data_Out`=1 in DRAIN: the sample is discarded, `Overrun <= 1`, and the pointers and FSM are unaffected.
  - `Overrun` clears only on reset.
- No arithmetic on data: bits pass through unchanged, with no sign extension or scaling.

## Timing
- Reset (`rst`=0, asynchronous): FSM = IDLE; `wr_cnt`=`rd_cnt`=0; `Rd_Valid`=0, `Rd_Data`=0, `Rd_Last`=0, `Frame_Done`=0, `Overrun`=0, `Busy`=0.
- Reset mid-CAPTURE or mid-DRAIN: the partial frame is abandoned. The first `Data_Out`=1 after release starts a new frame at index 0.
- Capture latency: with 64 contiguous `Data_Out` cycles N..N+63, `Frame_Done`=1 and `Rd_Valid`=1 in cycle N+64.
- Drain: with `Rd_Ready` held at 1, bins 0..63 appear in cycles N+64..N+127.
  - `Rd_Last`=1 in cycle N+127.
  - `Rd_Valid`=0 and `Busy`=0 in cycle N+128.
- Back-to-back frames: a frame whose first sample arrives in the cycle the last bin transfers is dropped, not captured. Capture resumes from IDLE on the next cycle.
- `Busy` is registered state, 1 from the cycle after the first sample is accepted until the cycle after the last transfer.

## Test plan
- Ramp frame, `BIT_REVERSE`=1, sample i = {i[15:0], ~i[15:0]}, 64 contiguous cycles, `Rd_Ready`=1.
  - Bin k = sample bitrev6(k): bin 1 = 0x0020FFDF, bin 63 = 0x003FFFC0.
  - `Frame_Done` pulses in cycle N+64; `Rd_Last` only on bin 63.
- `BIT_REVERSE`=0, constant 0x00290000 for 64 cycles.
  - 64 bins of 0x00290000, then `Rd_Valid`=0.
- Gapped input: `Data_Out` toggles 1/0 for 128 cycles.
  - `Frame_Done` after the 64th sample (cycle N+127).
  - Contents identical to the contiguous ramp case.
- Backpressure: `Rd_Ready` = 1,0,0,1 repeating.
  - `Rd_Data` stable while stalled.
  - Exactly 64 transfers, no duplicates or skips.
  - `Rd_Last` on the 64th transfer.
- Overrun: assert `Data_Out` for 3 cycles during DRAIN.
  - `Overrun`=1 and sticky; drained data unchanged.
  - Next frame after IDLE captured correctly.
- Async reset: drive `rst`=0 mid-capture at sample 30, off-clock-edge.
  - All outputs 0 immediately.
  - After release, a new 64-sample frame drains correctly from bin 0.
